lcd_rgb_rx: RTL and testbench

//  Receive end of the parallel RGB565 LCD interface (DE/HSYNC/VSYNC + 5/6/5 data) driven by our timing generator.

---
 rtl/lcd_rgb_rx.sv | 256 +++++++++++++++++++++++++
 tb/tb_lcd_rgb_rx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_rgb_rx.sv
// lcd_rgb_rx: receive side of the parallel RGB565 LCD interface.
// Recovers pixel coordinates, measures line/frame geometry and runs a
// SEARCH/MEASURE/LOCKED lock machine against H_ACTIVE x V_ACTIVE.
// Optional feature macro: LCD_RX_CRC_EN adds a per-frame CRC-16-CCITT output.
module lcd_rgb_rx #(
  parameter int unsigned H_ACTIVE    = 480,
  parameter int unsigned V_ACTIVE    = 272,
  parameter int unsigned CW          = 11,
  parameter int unsigned LOCK_FRAMES = 2,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0
) (
  input  logic          PixelClk,
  input  logic          nRST,
  input  logic          LCD_DE,
  input  logic          LCD_HSYNC,
  input  logic          LCD_VSYNC,
  input  logic [4:0]    LCD_R,
  input  logic [5:0]    LCD_G,
  input  logic [4:0]    LCD_B,
  output logic          pix_valid,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic [15:0]   pix_data,
  output logic          frame_start,
  output logic          line_end,
  output logic [CW-1:0] meas_width,
  output logic [CW-1:0] meas_height,
  output logic [CW-1:0] meas_htotal,
  output logic          locked,
  output logic          sync_err
`ifdef LCD_RX_CRC_EN
  ,output logic [15:0]  frame_crc
`endif
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam int unsigned   GW     = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] CMAX   = '1;
  localparam logic [CW-1:0] H_EXP  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_EXP  = CW'(V_ACTIVE);
  localparam logic [GW-1:0] G_LAST = GW'(LOCK_FRAMES - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  logic          de_s1_q, hs_s1_q, vs_s1_q, de_s2_q, hs_s2_q, vs_s2_q;
  logic [15:0]   rgb_s1_q;
  logic [CW-1:0] x_q, x_d, y_q, y_d, htot_q, htot_d;
  logic          frame_bad_q, frame_bad_d, abort_q, abort_d;
  state_t        state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic          pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
  logic          line_end_q, line_end_d, locked_q, locked_d, sync_err_q, sync_err_d;
  logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0]   pix_data_q, pix_data_d;
  logic [CW-1:0] meas_w_q, meas_w_d, meas_h_q, meas_h_d, meas_ht_q, meas_ht_d;

  logic          de_rise, de_fall, hs_rise, vs_rise;
  logic          abort_now, abort_eff, live, end_line, width_bad, bad_fin, frame_good;
  logic [CW-1:0] cur_x, y_fin;

`ifdef LCD_RX_CRC_EN
  logic [15:0] crc_q, crc_d, frame_crc_q, frame_crc_d;

  function automatic logic [15:0] crc16_word(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int unsigned i = 0; i < 16; i++) begin
      fb = r[15] ^ d[15 - i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction
`endif

  // Pin capture (s1) with sync levels normalised to "asserted", then s2 for edges.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      de_s1_q  <= 1'b0;
      hs_s1_q  <= 1'b0;
      vs_s1_q  <= 1'b0;
      rgb_s1_q <= '0;
      de_s2_q  <= 1'b0;
      hs_s2_q  <= 1'b0;
      vs_s2_q  <= 1'b0;
    end else begin
      de_s1_q  <= LCD_DE;
      hs_s1_q  <= (LCD_HSYNC == HS_POL);
      vs_s1_q  <= (LCD_VSYNC == VS_POL);
      rgb_s1_q <= {LCD_R, LCD_G, LCD_B};
      de_s2_q  <= de_s1_q;
      hs_s2_q  <= hs_s1_q;
      vs_s2_q  <= vs_s1_q;
    end
  end

  // Coordinate recovery, measurements, frame check and lock next-state.
  always_comb begin
    de_rise   = de_s1_q & ~de_s2_q;
    de_fall   = ~de_s1_q & de_s2_q;
    hs_rise   = hs_s1_q & ~hs_s2_q;
    vs_rise   = vs_s1_q & ~vs_s2_q;
    // A VSYNC landing inside DE aborts the rest of that line: no pixels,
    // no line_end, no y step; the abort flag clears on the next DE rise.
    abort_now = vs_rise & de_s1_q;
    abort_eff = abort_q & ~de_rise;
    live      = de_s1_q & ~abort_eff & ~abort_now;
    end_line  = de_fall & ~abort_eff;
    width_bad = end_line & (x_q != H_EXP);
    cur_x     = de_rise ? '0 : x_q;
    // Fold a line ending on the VSYNC cycle itself into the frame verdict.
    y_fin      = end_line ? sat_inc(y_q) : y_q;
    bad_fin    = frame_bad_q | width_bad;
    frame_good = ~bad_fin & (y_fin == V_EXP);

    x_d         = live ? sat_inc(cur_x) : x_q;
    pix_valid_d = live;
    pix_x_d     = live ? cur_x : pix_x_q;
    pix_y_d     = live ? y_q : pix_y_q;
    pix_data_d  = live ? rgb_s1_q : pix_data_q;
    line_end_d  = end_line;
    meas_w_d    = end_line ? x_q : meas_w_q;
    y_d         = end_line ? sat_inc(y_q) : y_q;
    frame_bad_d = bad_fin;
    abort_d     = de_rise ? 1'b0 : abort_q;
    meas_ht_d   = hs_rise ? htot_q : meas_ht_q;
    htot_d      = hs_rise ? CW'(1) : sat_inc(htot_q);

    frame_start_d = vs_rise;
    meas_h_d      = meas_h_q;
    state_d       = state_q;
    good_d        = good_q;
    sync_err_d    = width_bad & (state_q == LOCKED);

    if (vs_rise) begin
      meas_h_d    = y_fin;
      y_d         = '0;
      frame_bad_d = abort_now;
      if (abort_now) abort_d = 1'b1;
      case (state_q)
        SEARCH: begin
          state_d = MEASURE;
          good_d  = '0;
        end
        MEASURE: begin
          if (!frame_good) begin
            good_d = '0;
          end else if (good_q >= G_LAST) begin
            state_d = LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
        LOCKED: begin
          if (!frame_good) begin
            sync_err_d = 1'b1;
            state_d    = MEASURE;
            good_d     = '0;
          end
        end
        default: begin
          state_d = SEARCH;
          good_d  = '0;
        end
      endcase
    end

    locked_d = (state_q == LOCKED);
  end

`ifdef LCD_RX_CRC_EN
  // Running CRC over delivered pixels; latched and re-initialised per frame.
  always_comb begin
    crc_d       = live ? crc16_word(crc_q, rgb_s1_q) : crc_q;
    frame_crc_d = frame_crc_q;
    if (vs_rise) begin
      frame_crc_d = crc_d;
      crc_d       = 16'hFFFF;
    end
  end

  // CRC state registers.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      crc_q       <= 16'hFFFF;
      frame_crc_q <= '0;
    end else begin
      crc_q       <= crc_d;
      frame_crc_q <= frame_crc_d;
    end
  end

  assign frame_crc = frame_crc_q;
`endif

  // State and output registers.
  always_ff @(posedge PixelClk) begin
    if (!nRST) begin
      x_q           <= '0;
      y_q           <= '0;
      htot_q        <= '0;
      frame_bad_q   <= 1'b0;
      abort_q       <= 1'b0;
      state_q       <= SEARCH;
      good_q        <= '0;
      pix_valid_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_data_q    <= '0;
      frame_start_q <= 1'b0;
      line_end_q    <= 1'b0;
      meas_w_q      <= '0;
      meas_h_q      <= '0;
      meas_ht_q     <= '0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      htot_q        <= htot_d;
      frame_bad_q   <= frame_bad_d;
      abort_q       <= abort_d;
      state_q       <= state_d;
      good_q        <= good_d;
      pix_valid_q   <= pix_valid_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_data_q    <= pix_data_d;
      frame_start_q <= frame_start_d;
      line_end_q    <= line_end_d;
      meas_w_q      <= meas_w_d;
      meas_h_q      <= meas_h_d;
      meas_ht_q     <= meas_ht_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_data    = pix_data_q;
  assign frame_start = frame_start_q;
  assign line_end    = line_end_q;
  assign meas_width  = meas_w_q;
  assign meas_height = meas_h_q;
  assign meas_htotal = meas_ht_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// tb_lcd_rgb_rx: directed bench for lcd_rgb_rx with pixel and event scoreboards.
// Geometry is scaled down (120x6) so a dozen frames stay short.
module tb_lcd_rgb_rx;
  localparam int unsigned H   = 120;
  localparam int unsigned V   = 6;
  localparam int unsigned CW  = 11;
  localparam bit          HSP = 1'b0;
  localparam bit          VSP = 1'b0;
  localparam logic [2:0]  EV_FS = 3'b100, EV_LE = 3'b010, EV_SE = 3'b001;

  logic          PixelClk = 1'b0;
  logic          nRST, LCD_DE, LCD_HSYNC, LCD_VSYNC;
  logic [4:0]    LCD_R, LCD_B;
  logic [5:0]    LCD_G;
  logic          pix_valid, frame_start, line_end, locked, sync_err;
  logic [CW-1:0] pix_x, pix_y, meas_width, meas_height, meas_htotal;
  logic [15:0]   pix_data;
`ifdef LCD_RX_CRC_EN
  logic [15:0]   frame_crc;
`endif

  lcd_rgb_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .CW(CW), .LOCK_FRAMES(2),
               .HS_POL(HSP), .VS_POL(VSP)) dut (
    .PixelClk(PixelClk), .nRST(nRST), .LCD_DE(LCD_DE), .LCD_HSYNC(LCD_HSYNC),
    .LCD_VSYNC(LCD_VSYNC), .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .line_end(line_end), .meas_width(meas_width),
    .meas_height(meas_height), .meas_htotal(meas_htotal), .locked(locked),
    .sync_err(sync_err)
`ifdef LCD_RX_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );

  always #5 PixelClk = ~PixelClk;

  int cyc = 0;
  always @(posedge PixelClk) cyc <= cyc + 1;

  typedef struct {int cyc; logic [CW-1:0] x; logic [CW-1:0] y; logic [15:0] d;} pix_t;
  typedef struct {int cyc; logic [2:0] f;} ev_t;
  pix_t pq[$];
  ev_t  eq[$];

  int n_cmp = 0, n_fail = 0;
  logic [15:0] fixw [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
  int fix_idx = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef LCD_RX_CRC_EN
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [15:0] d);
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  // Pixel scoreboard: every pix_valid must match the oldest pushed pixel, on time.
  always @(negedge PixelClk) begin
    pix_t e;
    if (pix_valid === 1'b1) begin
      if (pq.size() == 0) begin
        chk("pix_unexpected", 1, 0);
      end else begin
        e = pq.pop_front();
        chk("pix_latency", cyc, e.cyc);
        chk("pix_x", pix_x, e.x);
        chk("pix_y", pix_y, e.y);
        chk("pix_data", pix_data, e.d);
      end
    end else if (pq.size() != 0 && pq[0].cyc <= cyc) begin
      e = pq.pop_front();
      chk("pix_missing", 0, 1);
    end
  end

  // Event scoreboard: frame_start/line_end/sync_err pulses only where expected.
  always @(negedge PixelClk) begin
    logic [2:0] exp_f;
    exp_f = 3'b000;
    if (eq.size() != 0 && eq[0].cyc <= cyc) exp_f = eq.pop_front().f;
    if ({frame_start, line_end, sync_err} !== 3'b000 || exp_f != 3'b000)
      chk("events{fs,le,se}", {frame_start, line_end, sync_err}, exp_f);
  end

  task automatic cycle(input bit de, input bit hs, input bit vs, input logic [15:0] d);
    @(negedge PixelClk);
    LCD_DE    = de;
    LCD_HSYNC = hs ? HSP : ~HSP;
    LCD_VSYNC = vs ? VSP : ~VSP;
    {LCD_R, LCD_G, LCD_B} = d;
  endtask

  task automatic push_pix(input int x, input int y, input logic [15:0] d);
    pix_t e;
    e.cyc = cyc + 2; e.x = CW'(x); e.y = CW'(y); e.d = d;
    pq.push_back(e);
  endtask

  task automatic push_ev(input logic [2:0] f);
    ev_t e;
    e.cyc = cyc + 2; e.f = f;
    eq.push_back(e);
  endtask

  // One line: HSYNC 4, back porch 3, w DE cycles, front porch 3 (total w+10).
  task automatic do_line(input int w, input int y, input bit err, input bit fixed);
    logic [15:0] d;
    repeat (4) cycle(0, 1, 0, 16'h0);
    repeat (3) cycle(0, 0, 0, 16'h0);
    for (int i = 0; i < w; i++) begin
      if (fixed) begin
        d = fixw[fix_idx];
        fix_idx++;
      end else begin
        d = 16'($urandom);
      end
      cycle(1, 0, 0, d);
      push_pix(i, y, d);
    end
    cycle(0, 0, 0, 16'h0);
    push_ev(EV_LE | (err ? EV_SE : 3'b000));
    repeat (2) cycle(0, 0, 0, 16'h0);
    chk("meas_width", meas_width, w);
  endtask

  task automatic frame(input int n, input int short_idx);
    int w, prev_w;
    prev_w = 0;
    for (int l = 0; l < n; l++) begin
      w = (l == short_idx) ? H - 1 : H;
      do_line(w, l, l == short_idx, 1'b0);
      if (l > 0) chk("meas_htotal", meas_htotal, prev_w + 10);
      prev_w = w;
    end
  endtask

  task automatic vsync(input bit err, input bit exp_lock, input int exp_h);
    cycle(0, 0, 1, 16'h0);
    push_ev(EV_FS | (err ? EV_SE : 3'b000));
    cycle(0, 0, 1, 16'h0);
    cycle(0, 0, 0, 16'h0);
    cycle(0, 0, 0, 16'h0);
    chk("locked", locked, exp_lock);
    chk("meas_height", meas_height, exp_h);
    cycle(0, 0, 0, 16'h0);
  endtask

  // Line whose DE is interrupted by VSYNC at pixel 100.
  task automatic abort_line(input int y, input bit err);
    logic [15:0] d;
    repeat (4) cycle(0, 1, 0, 16'h0);
    repeat (3) cycle(0, 0, 0, 16'h0);
    for (int i = 0; i < H; i++) begin
      d = 16'($urandom);
      cycle(1, 0, (i >= 100 && i < 103), d);
      if (i < 100) push_pix(i, y, d);
      if (i == 100) push_ev(EV_FS | (err ? EV_SE : 3'b000));
    end
    repeat (3) cycle(0, 0, 0, 16'h0);
    chk("abort_locked", locked, 0);
    chk("abort_meas_height", meas_height, y);
  endtask

  initial begin
    nRST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      LCD_DE    = 1'($urandom);
      LCD_HSYNC = 1'($urandom);
      LCD_VSYNC = 1'($urandom);
      {LCD_R, LCD_G, LCD_B} = 16'($urandom);
      @(negedge PixelClk);
    end
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_xy", {pix_x, pix_y}, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pulses", {frame_start, line_end, sync_err}, 0);
    chk("rst_meas", {meas_width, meas_height, meas_htotal}, 0);
    chk("rst_locked", locked, 0);
`ifdef LCD_RX_CRC_EN
    chk("rst_frame_crc", frame_crc, 0);
`endif
    nRST = 1'b1;
    LCD_DE = 1'b0; LCD_HSYNC = ~HSP; LCD_VSYNC = ~VSP;
    {LCD_R, LCD_G, LCD_B} = 16'h0;
    repeat (4) cycle(0, 0, 0, 16'h0);

    // Partial frame while searching, then first VSYNC.
    do_line(H - 3, 0, 0, 1'b0);
    vsync(0, 0, 1);
    // 2x2 frame of fixed words (bad geometry, no lock progress).
    do_line(2, 0, 0, 1'b1);
    do_line(2, 1, 0, 1'b1);
    vsync(0, 0, 2);
`ifdef LCD_RX_CRC_EN
    chk("frame_crc", frame_crc,
        ref_crc(ref_crc(ref_crc(ref_crc(16'hFFFF, 16'h1234), 16'h5678), 16'h9ABC), 16'hDEF0));
`endif
    // Nominal: two good frames lock, a third keeps lock.
    frame(V, -1); vsync(0, 0, V);
    frame(V, -1); vsync(0, 1, V);
    frame(V, -1); vsync(0, 1, V);
    // Short line while locked, then relock.
    frame(V, 2);  vsync(1, 0, V);
    frame(V, -1); vsync(0, 0, V);
    // Height error resets the good count.
    frame(V - 1, -1); vsync(0, 0, V - 1);
    frame(V, -1); vsync(0, 0, V);
    frame(V, -1); vsync(0, 1, V);
    // VSYNC during DE: truncated frame while locked, next frame counted bad.
    frame(3, -1);
    abort_line(3, 1);
    frame(V, -1); vsync(0, 0, V);
    frame(V, -1); vsync(0, 0, V);
    frame(V, -1); vsync(0, 1, V);

    repeat (10) cycle(0, 0, 0, 16'h0);
    chk("pix_queue_drained", pq.size(), 0);
    chk("event_queue_drained", eq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
